// File: rtl/lcd_rx_pkg.sv
// rtl/lcd_rx_pkg.sv - shared state type, default geometry and sync-edge helper for the LCD receive monitor
package lcd_rx_pkg;

  typedef enum logic {IDLE, FRAME} state_t;

  localparam int H_ACTIVE_DEF = 800;
  localparam int V_ACTIVE_DEF = 480;

  // True when a signal moves from the non-act level to the act level.
  function automatic logic sync_lead(input logic cur, input logic prev, input logic act);
    return (cur == act) && (prev != act);
  endfunction

endpackage

// File: rtl/lcd_rx_edge.sv
// rtl/lcd_rx_edge.sv - input register plus leading/trailing edge detect for one LCD control signal
module lcd_rx_edge
  import lcd_rx_pkg::*;
#(
  parameter logic ACT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic q_prev,
  output logic lead,
  output logic trail
);

  // Reset to the inactive level so a quiet line after reset shows no edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      q      <= ~ACT;
      q_prev <= ~ACT;
    end else begin
      q      <= d;
      q_prev <= q;
    end
  end

  assign lead  = sync_lead(q, q_prev, ACT);
  assign trail = sync_lead(q, q_prev, ~ACT);

endmodule

// File: rtl/lcd_rx_monitor.sv
// rtl/lcd_rx_monitor.sv - RGB LCD receive monitor: pixel coordinates, geometry measurement, error flags, pixel capture
module lcd_rx_monitor
  import lcd_rx_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter logic SYNC_ACT = 1'b0,
  parameter int   CW       = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [23:0]   rgb_in,
  input  logic          hsync_in,
  input  logic          vsync_in,
  input  logic          de_in,
  input  logic          err_clr,
  input  logic [CW-1:0] cap_x,
  input  logic [CW-1:0] cap_y,
  output logic [CW-1:0] pix_x,
  output logic [CW-1:0] pix_y,
  output logic [23:0]   pix_data,
  output logic          pix_valid,
  output logic          frame_start,
  output logic          frame_done,
  output logic [15:0]   frame_cnt,
  output logic [11:0]   h_total,
  output logic          err_hlen,
  output logic          err_vlen,
  output logic [23:0]   cap_data,
  output logic          cap_hit
);

  localparam logic [CW-1:0] H_A    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_A    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] C_MAX  = '1;
  localparam logic [11:0]   HT_MAX = 12'hFFF;

  logic [23:0] rgb_q;
  logic        clr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q <= '0;
      clr_q <= 1'b0;
    end else begin
      rgb_q <= rgb_in;
      clr_q <= err_clr;
    end
  end

  logic hs_q, hs_prev, hs_lead, hs_trail;
  logic vs_q, vs_prev, vs_lead, vs_trail;
  logic de_q, de_prev, de_lead, de_fall;

  lcd_rx_edge #(.ACT(SYNC_ACT)) u_hs (
    .clk(clk), .rst(rst), .d(hsync_in),
    .q(hs_q), .q_prev(hs_prev), .lead(hs_lead), .trail(hs_trail)
  );

  lcd_rx_edge #(.ACT(SYNC_ACT)) u_vs (
    .clk(clk), .rst(rst), .d(vsync_in),
    .q(vs_q), .q_prev(vs_prev), .lead(vs_lead), .trail(vs_trail)
  );

  lcd_rx_edge #(.ACT(1'b1)) u_de (
    .clk(clk), .rst(rst), .d(de_in),
    .q(de_q), .q_prev(de_prev), .lead(de_lead), .trail(de_fall)
  );

  logic unused_edges;
  assign unused_edges = &{1'b0, hs_q, hs_prev, hs_trail, vs_q, vs_prev, vs_trail, de_lead};

  state_t        state;
  logic [CW-1:0] x, y, lines;
  logic [11:0]   hcnt;

  logic [CW-1:0] x_inc, y_inc, lines_inc, lines_at_vs;
  logic          in_frame, in_win, line_close, hlen_new, vlen_new, cap_match;

  assign x_inc     = (x == C_MAX)     ? x     : x + CW'(1);
  assign y_inc     = (y == C_MAX)     ? y     : y + CW'(1);
  assign lines_inc = (lines == C_MAX) ? lines : lines + CW'(1);

  assign in_frame = (state == FRAME);
  assign in_win   = (x < H_A) && (y < V_A);

  // A run still open at a vsync edge is closed there as if de had fallen.
  assign line_close  = in_frame && de_prev && (vs_lead || !de_q);
  assign lines_at_vs = de_prev ? lines_inc : lines;
  assign hlen_new    = line_close && (x != H_A);
  assign vlen_new    = in_frame && vs_lead && (lines_at_vs != V_A);
  assign cap_match   = in_frame && !vs_lead && de_q && in_win && (x == cap_x) && (y == cap_y);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      x           <= '0;
      y           <= '0;
      lines       <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_data    <= '0;
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
      err_hlen    <= 1'b0;
      err_vlen    <= 1'b0;
      cap_data    <= '0;
      cap_hit     <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
      pix_valid   <= 1'b0;
      cap_hit     <= 1'b0;
      // A fresh error in the same cycle as a clear keeps the flag set.
      err_hlen    <= (err_hlen & ~clr_q) | hlen_new;
      err_vlen    <= (err_vlen & ~clr_q) | vlen_new;

      if (cap_match) begin
        cap_data <= rgb_q;
        cap_hit  <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (vs_lead) begin
            frame_start <= 1'b1;
            x           <= '0;
            y           <= '0;
            lines       <= '0;
            state       <= FRAME;
          end
        end
        FRAME: begin
          if (vs_lead) begin
            frame_start <= 1'b1;
            frame_done  <= 1'b1;
            frame_cnt   <= frame_cnt + 16'd1;
            x           <= '0;
            y           <= '0;
            lines       <= '0;
          end else if (de_q) begin
            pix_valid <= in_win;
            pix_x     <= x;
            pix_y     <= y;
            pix_data  <= rgb_q;
            x         <= x_inc;
          end else if (de_prev) begin
            x     <= '0;
            y     <= y_inc;
            lines <= lines_inc;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line period counter runs regardless of frame state.
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt    <= '0;
      h_total <= '0;
    end else if (hs_lead) begin
      h_total <= hcnt;
      hcnt    <= 12'd1;
    end else if (hcnt != HT_MAX) begin
      hcnt <= hcnt + 12'd1;
    end
  end

endmodule

// File: tb/tb_lcd_rx_monitor.sv
// tb/tb_lcd_rx_monitor.sv - directed self-checking bench for lcd_rx_monitor
module tb_lcd_rx_monitor;

  localparam logic L = 1'b0;
  localparam logic H = 1'b1;

  logic        clk, rst, hsync_in, vsync_in, de_in, err_clr;
  logic [23:0] rgb_in;
  logic [10:0] cap_x, cap_y;

  logic [10:0] pix_x, pix_y, d_pix_x, d_pix_y;
  logic [23:0] pix_data, cap_data, d_pix_data, d_cap_data;
  logic        pix_valid, frame_start, frame_done, err_hlen, err_vlen, cap_hit;
  logic        d_pix_valid, d_frame_start, d_frame_done, d_err_hlen, d_err_vlen, d_cap_hit;
  logic [15:0] frame_cnt, d_frame_cnt;
  logic [11:0] h_total, d_h_total;

  lcd_rx_monitor #(.H_ACTIVE(8), .V_ACTIVE(4)) dut (
    .clk(clk), .rst(rst), .rgb_in(rgb_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .de_in(de_in), .err_clr(err_clr), .cap_x(cap_x), .cap_y(cap_y),
    .pix_x(pix_x), .pix_y(pix_y), .pix_data(pix_data), .pix_valid(pix_valid),
    .frame_start(frame_start), .frame_done(frame_done), .frame_cnt(frame_cnt),
    .h_total(h_total), .err_hlen(err_hlen), .err_vlen(err_vlen),
    .cap_data(cap_data), .cap_hit(cap_hit)
  );

  lcd_rx_monitor dut_def (
    .clk(clk), .rst(rst), .rgb_in(rgb_in), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .de_in(de_in), .err_clr(err_clr), .cap_x(cap_x), .cap_y(cap_y),
    .pix_x(d_pix_x), .pix_y(d_pix_y), .pix_data(d_pix_data), .pix_valid(d_pix_valid),
    .frame_start(d_frame_start), .frame_done(d_frame_done), .frame_cnt(d_frame_cnt),
    .h_total(d_h_total), .err_hlen(d_err_hlen), .err_vlen(d_err_vlen),
    .cap_data(d_cap_data), .cap_hit(d_cap_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int fs_n = 0, fd_n = 0, ch_n = 0;
  logic [45:0] pq[$];

  always @(negedge clk) begin
    if (pix_valid) pq.push_back({pix_y, pix_x, pix_data});
    if (frame_start) fs_n++;
    if (frame_done) fd_n++;
    if (cap_hit) ch_n++;
  end

  function automatic logic [23:0] enc(input int x, input int y);
    logic [7:0] xb, yb;
    xb = x[7:0];
    yb = y[7:0];
    return {8'hA5, yb, xb};
  endfunction

  function automatic logic [45:0] exp_px(input int x, input int y);
    logic [10:0] xx, yy;
    xx = x[10:0];
    yy = y[10:0];
    return {yy, xx, enc(x, y)};
  endfunction

  task automatic cyc(input logic hs, input logic vs, input logic de, input logic [23:0] rgb);
    hsync_in = hs; vsync_in = vs; de_in = de; rgb_in = rgb;
    @(posedge clk);
    #1;
  endtask

  task automatic line(input int y, input int n);
    cyc(L, H, L, 24'h0); cyc(L, H, L, 24'h0);
    cyc(H, H, L, 24'h0); cyc(H, H, L, 24'h0);
    for (int x = 0; x < n; x++) cyc(H, H, H, enc(x, y));
    cyc(H, H, L, 24'h0); cyc(H, H, L, 24'h0);
  endtask

  task automatic vs_pulse();
    cyc(H, L, L, 24'h0); cyc(H, L, L, 24'h0);
    cyc(H, H, L, 24'h0); cyc(H, H, L, 24'h0);
  endtask

  task automatic frame(input int nlines, input int long_y);
    for (int y = 0; y < nlines; y++) line(y, (y == long_y) ? 9 : 8);
  endtask

  task automatic test_reset();
    int s, f0;
    rst = 1'b1; err_clr = 1'b0; cap_x = 11'd100; cap_y = 11'd100;
    for (int i = 0; i < 3; i++) cyc(H, H, L, 24'h0);
    n_chk++;
    if ({pix_x, pix_y, pix_data, pix_valid, cap_data, cap_hit} !== '0) begin
      n_fail++; $display("FAIL reset_pix got %0h exp 0", {pix_x, pix_y, pix_data, pix_valid, cap_data, cap_hit});
    end
    n_chk++;
    if ({frame_start, frame_done, frame_cnt, h_total, err_hlen, err_vlen} !== '0) begin
      n_fail++; $display("FAIL reset_ctl got %0h exp 0", {frame_start, frame_done, frame_cnt, h_total, err_hlen, err_vlen});
    end
    rst = 1'b0;
    s = pq.size(); f0 = fs_n;
    line(0, 8);
    n_chk++;
    if (pq.size() - s !== 0) begin n_fail++; $display("FAIL idle_de_ignored got %0d exp 0", pq.size() - s); end
    n_chk++;
    if (fs_n - f0 !== 0) begin n_fail++; $display("FAIL idle_no_start got %0d exp 0", fs_n - f0); end
  endtask

  task automatic test_frames();
    int s, n, f0, d0;
    s = pq.size(); f0 = fs_n; d0 = fd_n;
    for (int f = 0; f < 3; f++) begin vs_pulse(); frame(4, -1); end
    n = pq.size() - s;
    n_chk++;
    if (n !== 96) begin n_fail++; $display("FAIL t1_pix_count got %0d exp 96", n); end
    for (int i = 0; i < n && i < 96; i++) begin
      n_chk++;
      if (pq[s+i] !== exp_px(i % 8, (i / 8) % 4)) begin
        n_fail++; $display("FAIL t1_pix[%0d] got %0h exp %0h", i, pq[s+i], exp_px(i % 8, (i / 8) % 4));
      end
    end
    n_chk++;
    if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL t1_frame_cnt got %0d exp 2", frame_cnt); end
    n_chk++;
    if (fs_n - f0 !== 3) begin n_fail++; $display("FAIL t1_frame_start got %0d exp 3", fs_n - f0); end
    n_chk++;
    if (fd_n - d0 !== 2) begin n_fail++; $display("FAIL t1_frame_done got %0d exp 2", fd_n - d0); end
    n_chk++;
    if ({err_hlen, err_vlen} !== 2'b00) begin n_fail++; $display("FAIL t1_errors got %b exp 00", {err_hlen, err_vlen}); end
    n_chk++;
    if (h_total !== 12'd14) begin n_fail++; $display("FAIL t1_h_total got %0d exp 14", h_total); end
  endtask

  task automatic test_hlen();
    int s, n;
    vs_pulse();
    n_chk++;
    if (frame_cnt !== 16'd3) begin n_fail++; $display("FAIL t2_frame_cnt got %0d exp 3", frame_cnt); end
    s = pq.size();
    line(0, 8); line(1, 8);
    n_chk++;
    if (err_hlen !== 1'b0) begin n_fail++; $display("FAIL t2_hlen_early got %b exp 0", err_hlen); end
    line(2, 9);
    n_chk++;
    if (err_hlen !== 1'b1) begin n_fail++; $display("FAIL t2_hlen_set got %b exp 1", err_hlen); end
    line(3, 8);
    n = pq.size() - s;
    n_chk++;
    if (n !== 32) begin n_fail++; $display("FAIL t2_pix_count got %0d exp 32", n); end
    for (int i = 0; i < n && i < 32; i++) begin
      n_chk++;
      if (pq[s+i] !== exp_px(i % 8, i / 8)) begin
        n_fail++; $display("FAIL t2_pix[%0d] got %0h exp %0h", i, pq[s+i], exp_px(i % 8, i / 8));
      end
    end
    n_chk++;
    if (err_vlen !== 1'b0) begin n_fail++; $display("FAIL t2_vlen got %b exp 0", err_vlen); end
    err_clr = 1'b1; cyc(H, H, L, 24'h0); err_clr = 1'b0;
    cyc(H, H, L, 24'h0); cyc(H, H, L, 24'h0);
    n_chk++;
    if (err_hlen !== 1'b0) begin n_fail++; $display("FAIL t2_hlen_clr got %b exp 0", err_hlen); end
  endtask

  task automatic test_vlen();
    int s, n;
    vs_pulse();
    n_chk++;
    if (err_vlen !== 1'b0) begin n_fail++; $display("FAIL t3_vlen_ok got %b exp 0", err_vlen); end
    s = pq.size();
    frame(5, -1);
    n = pq.size() - s;
    n_chk++;
    if (n !== 32) begin n_fail++; $display("FAIL t3_pix_count got %0d exp 32", n); end
    for (int i = 0; i < n && i < 32; i++) begin
      n_chk++;
      if (pq[s+i] !== exp_px(i % 8, i / 8)) begin
        n_fail++; $display("FAIL t3_pix[%0d] got %0h exp %0h", i, pq[s+i], exp_px(i % 8, i / 8));
      end
    end
    err_clr = 1'b1; cyc(H, L, L, 24'h0); err_clr = 1'b0;
    cyc(H, L, L, 24'h0); cyc(H, H, L, 24'h0); cyc(H, H, L, 24'h0);
    n_chk++;
    if (err_vlen !== 1'b1) begin n_fail++; $display("FAIL t3_vlen_err_wins got %b exp 1", err_vlen); end
    n_chk++;
    if (frame_cnt !== 16'd5) begin n_fail++; $display("FAIL t3_frame_cnt got %0d exp 5", frame_cnt); end
    err_clr = 1'b1; cyc(H, H, L, 24'h0); err_clr = 1'b0;
    cyc(H, H, L, 24'h0); cyc(H, H, L, 24'h0);
    n_chk++;
    if ({err_hlen, err_vlen} !== 2'b00) begin n_fail++; $display("FAIL t3_clr got %b exp 00", {err_hlen, err_vlen}); end
  endtask

  task automatic test_capture();
    int c0;
    cap_x = 11'd3; cap_y = 11'd2;
    c0 = ch_n;
    frame(4, -1);
    n_chk++;
    if (ch_n - c0 !== 1) begin n_fail++; $display("FAIL t4_hit_cycles got %0d exp 1", ch_n - c0); end
    n_chk++;
    if (cap_data !== enc(3, 2)) begin n_fail++; $display("FAIL t4_cap_data got %0h exp %0h", cap_data, enc(3, 2)); end
    cap_x = 11'd9; cap_y = 11'd0;
    vs_pulse();
    c0 = ch_n;
    frame(4, -1);
    n_chk++;
    if (ch_n - c0 !== 0) begin n_fail++; $display("FAIL t4_no_hit got %0d exp 0", ch_n - c0); end
    n_chk++;
    if (cap_data !== enc(3, 2)) begin n_fail++; $display("FAIL t4_cap_hold got %0h exp %0h", cap_data, enc(3, 2)); end
    cap_x = 11'd100; cap_y = 11'd100;
  endtask

  task automatic test_mid_reset();
    int s, f0, d0;
    vs_pulse();
    line(0, 8); line(1, 8);
    cyc(L, H, L, 24'h0); cyc(L, H, L, 24'h0); cyc(H, H, L, 24'h0); cyc(H, H, L, 24'h0);
    for (int x = 0; x < 3; x++) cyc(H, H, H, enc(x, 2));
    rst = 1'b1;
    cyc(H, H, H, enc(3, 2)); cyc(H, H, H, enc(4, 2));
    n_chk++;
    if ({frame_cnt, pix_valid, pix_x, pix_y, pix_data, err_hlen, err_vlen, cap_data, h_total} !== '0) begin
      n_fail++; $display("FAIL t5_reset_outputs got %0h exp 0",
        {frame_cnt, pix_valid, pix_x, pix_y, pix_data, err_hlen, err_vlen, cap_data, h_total});
    end
    rst = 1'b0;
    s = pq.size();
    for (int x = 5; x < 9; x++) cyc(H, H, H, enc(x, 2));
    cyc(H, H, L, 24'h0); cyc(H, H, L, 24'h0);
    line(3, 8);
    n_chk++;
    if (pq.size() - s !== 0) begin n_fail++; $display("FAIL t5_de_ignored got %0d exp 0", pq.size() - s); end
    f0 = fs_n; d0 = fd_n;
    vs_pulse();
    n_chk++;
    if ({fs_n - f0, fd_n - d0} !== {32'd1, 32'd0}) begin
      n_fail++; $display("FAIL t5_first_vsync start=%0d done=%0d exp 1 0", fs_n - f0, fd_n - d0);
    end
    n_chk++;
    if (frame_cnt !== 16'd0) begin n_fail++; $display("FAIL t5_cnt_aborted got %0d exp 0", frame_cnt); end
    frame(4, -1);
    vs_pulse();
    n_chk++;
    if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL t5_cnt_after got %0d exp 1", frame_cnt); end
    n_chk++;
    if ({err_hlen, err_vlen} !== 2'b00) begin n_fail++; $display("FAIL t5_errors got %b exp 00", {err_hlen, err_vlen}); end
  endtask

  task automatic test_h_total();
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 4; i++) cyc(L, H, L, 24'h0);
      for (int i = 0; i < 1052; i++) cyc(H, H, L, 24'h0);
    end
    n_chk++;
    if (d_h_total !== 12'd1056) begin n_fail++; $display("FAIL t6_h_total got %0d exp 1056", d_h_total); end
    n_chk++;
    if (h_total !== 12'd1056) begin n_fail++; $display("FAIL t6_h_total_small got %0d exp 1056", h_total); end
    for (int i = 0; i < 5000; i++) cyc(H, H, L, 24'h0);
    cyc(L, H, L, 24'h0); cyc(L, H, L, 24'h0); cyc(H, H, L, 24'h0); cyc(H, H, L, 24'h0);
    n_chk++;
    if (d_h_total !== 12'd4095) begin n_fail++; $display("FAIL t6_h_total_sat got %0d exp 4095", d_h_total); end
  endtask

  initial begin
    rst = 1'b1; hsync_in = H; vsync_in = H; de_in = L; rgb_in = 24'h0;
    err_clr = 1'b0; cap_x = 11'd100; cap_y = 11'd100;
    test_reset();
    test_frames();
    test_hlen();
    test_vlen();
    test_capture();
    test_mid_reset();
    test_h_total();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
